// File: rtl/ysyx_24100006_rd_xbar_pkg.sv
// ysyx_24100006_rd_xbar_pkg: shared state encoding, target select and response codes
// for the read crossbar.
`timescale 1ns/1ps
`default_nettype none

package ysyx_24100006_rd_xbar_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLINT_REQ  = 3'd1,
        CLINT_WAIT = 3'd2,
        MEM_AR     = 3'd3,
        MEM_R      = 3'd4,
        ERR        = 3'd5,
        RESP       = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TGT_CLINT = 2'd0,
        TGT_MEM   = 2'd1,
        TGT_ERR   = 2'd2
    } tgt_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unsigned offset compare: addresses below BASE wrap to huge offsets and miss.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return off < size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_24100006_rd_addr_dec.sv
// ysyx_24100006_rd_addr_dec: combinational read-address decoder selecting CLINT,
// main memory or the local error responder.
`timescale 1ns/1ps
`default_nettype none

module ysyx_24100006_rd_addr_dec
    import ysyx_24100006_rd_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_SIZE = 32'h0001_0000,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
    input  logic [31:0] i_addr,
    output tgt_e        o_tgt
);

    logic w_clint_hit;
    logic w_mem_hit;

    assign w_clint_hit = in_window(i_addr, CLINT_BASE, CLINT_SIZE);
    assign w_mem_hit   = in_window(i_addr, MEM_BASE, MEM_SIZE);

    // CLINT wins when the windows overlap.
    always_comb begin
        o_tgt = TGT_ERR;
        if (w_clint_hit) begin
            o_tgt = TGT_CLINT;
        end else if (w_mem_hit) begin
            o_tgt = TGT_MEM;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_24100006_rd_xbar.sv
// ysyx_24100006_rd_xbar: AXI-Lite read crossbar, LSU master to CLINT / main memory,
// one transaction in flight. Define RD_XBAR_PERF_EN to add performance counters.
`timescale 1ns/1ps
`default_nettype none

module ysyx_24100006_rd_xbar
    import ysyx_24100006_rd_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_SIZE = 32'h0001_0000,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic        m_rvalid,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    input  logic        m_rready,
    output logic [31:0] clint_araddr,
    output logic        clint_arvalid,
    input  logic        clint_rvalid,
    input  logic [31:0] clint_rdata,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready
`ifdef RD_XBAR_PERF_EN
    ,
    output logic [31:0] perf_clint_cnt,
    output logic [31:0] perf_mem_cnt,
    output logic [31:0] perf_err_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    state_e      r_state;
    logic [31:0] r_addr;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_clint_arvalid;
    logic        r_mem_arvalid;
    logic        r_mem_rready;
    tgt_e        w_tgt;
    logic        w_ar_hs;

    ysyx_24100006_rd_addr_dec #(
        .CLINT_BASE (CLINT_BASE),
        .CLINT_SIZE (CLINT_SIZE),
        .MEM_BASE   (MEM_BASE),
        .MEM_SIZE   (MEM_SIZE)
    ) u_dec (
        .i_addr (m_araddr),
        .o_tgt  (w_tgt)
    );

    assign w_ar_hs = (r_state == IDLE) && m_arvalid && r_arready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_addr          <= 32'h0;
            r_arready       <= 1'b0;
            r_rvalid        <= 1'b0;
            r_rdata         <= 32'h0;
            r_rresp         <= RESP_OKAY;
            r_clint_arvalid <= 1'b0;
            r_mem_arvalid   <= 1'b0;
            r_mem_rready    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // arready comes up one cycle after reset release so all outputs start at 0.
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_addr    <= m_araddr;
                        r_arready <= 1'b0;
                        case (w_tgt)
                            TGT_CLINT: begin
                                r_state         <= CLINT_REQ;
                                r_clint_arvalid <= 1'b1;
                            end
                            TGT_MEM: begin
                                r_state       <= MEM_AR;
                                r_mem_arvalid <= 1'b1;
                            end
                            default: r_state <= ERR;
                        endcase
                    end
                end
                CLINT_REQ: begin
                    r_clint_arvalid <= 1'b0;
                    r_state         <= CLINT_WAIT;
                end
                CLINT_WAIT: begin
                    if (clint_rvalid) begin
                        r_rdata  <= clint_rdata;
                        r_rresp  <= RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                MEM_AR: begin
                    if (mem_arready) begin
                        r_mem_arvalid <= 1'b0;
                        r_mem_rready  <= 1'b1;
                        r_state       <= MEM_R;
                    end
                end
                MEM_R: begin
                    if (mem_rvalid) begin
                        r_rdata      <= mem_rdata;
                        r_rresp      <= mem_rresp;
                        r_mem_rready <= 1'b0;
                        r_rvalid     <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                ERR: begin
                    r_rdata  <= 32'h0;
                    r_rresp  <= RESP_DECERR;
                    r_rvalid <= 1'b1;
                    r_state  <= RESP;
                end
                RESP: begin
                    if (m_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_arready     = r_arready;
    assign m_rvalid      = r_rvalid;
    assign m_rdata       = r_rdata;
    assign m_rresp       = r_rresp;
    assign clint_araddr  = r_addr;
    assign clint_arvalid = r_clint_arvalid;
    assign mem_araddr    = r_addr;
    assign mem_arvalid   = r_mem_arvalid;
    assign mem_rready    = r_mem_rready;

`ifdef RD_XBAR_PERF_EN
    tgt_e        r_tgt;
    logic [31:0] r_perf_clint;
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_err;
    logic [31:0] r_perf_stall;
    logic        w_r_hs;

    assign w_r_hs = (r_state == RESP) && m_rready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tgt        <= TGT_ERR;
            r_perf_clint <= 32'h0;
            r_perf_mem   <= 32'h0;
            r_perf_err   <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_ar_hs) begin
                r_tgt <= w_tgt;
            end
            if (w_r_hs) begin
                case (r_tgt)
                    TGT_CLINT: r_perf_clint <= r_perf_clint + 32'd1;
                    TGT_MEM:   r_perf_mem   <= r_perf_mem + 32'd1;
                    default:   r_perf_err   <= r_perf_err + 32'd1;
                endcase
            end
            if (r_state != IDLE) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_clint_cnt = r_perf_clint;
    assign perf_mem_cnt   = r_perf_mem;
    assign perf_err_cnt   = r_perf_err;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

`default_nettype wire
